mem_copy_engine: RTL and testbench

- Bus initiator that copies a block of words from a ROM-style source into a RAM-style sink.
- Source timing: registered read, 1-cycle latency. Sink timing: combinational read, write on the CLK edge when WE=1.
- Used to load NN weights and program images from the boot ROM into the PIM working RAM without core involvement.
- Streams one word per cycle after a 1-cycle fill, and produces a running checksum of the copied data.

---
 rtl/mem_copy_engine.sv | 187 ++++++++++++++++++
 tb/tb_mem_copy_engine.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// Block-copy initiator: streams words from a 1-cycle-latency ROM into a
// write-on-edge RAM and keeps a running mod-2^32 checksum of the copied words.
module mem_copy_engine #(
    parameter int unsigned ROM_LEN = 128,
    parameter int unsigned RAM_LEN = 1024
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] src_base_i,
    input  logic [31:0] dst_base_i,
    input  logic [31:0] len_i,
    output logic [31:0] rom_a_o,
    input  logic [31:0] rom_q_i,
    output logic [31:0] ram_a_o,
    output logic [31:0] ram_d_o,
    output logic        ram_we_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] csum_o
);

    // state  | meaning
    // IDLE   | waiting for START; ROM_A/RAM_A hold
    // FILL   | first ROM read in flight, no write yet
    // STREAM | one write per cycle while further reads are issued
    // DRAIN  | final write, DONE follows
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] rom_a_q;
    logic [31:0] wr_ptr_q;
    logic [31:0] dst_q;
    logic [31:0] left_q;
    logic [31:0] csum_q;
    logic        done_q;
    logic        err_q;

    logic        len_zero;
    logic        range_bad;
    logic        accept;
    logic        write_en;
    logic [32:0] src_end;
    logic [32:0] dst_end;

    // 33-bit sums so that a base near 2^32 counts as out of range
    assign src_end   = {1'b0, src_base_i} + {1'b0, len_i};
    assign dst_end   = {1'b0, dst_base_i} + {1'b0, len_i};
    assign len_zero  = (len_i == 32'd0);
    assign range_bad = (src_end > 33'(ROM_LEN)) || (dst_end > 33'(RAM_LEN));
    assign accept    = (state_q == IDLE) && start_i && !len_zero && !range_bad;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (left_q == 32'd1) begin
                    state_d = DRAIN;
                end else begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (left_q == 32'd2) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // An abort suppresses the write of the cycle it arrives in, so CSUM
    // only ever covers words that actually reached the RAM.
    always_comb begin
        busy_o   = 1'b0;
        write_en = 1'b0;
        case (state_q)
            FILL: begin
                busy_o = 1'b1;
            end
            STREAM, DRAIN: begin
                busy_o   = 1'b1;
                write_en = !abort_i;
            end
            default: begin
                busy_o   = 1'b0;
                write_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rom_a_q  <= 32'd0;
            wr_ptr_q <= 32'd0;
            dst_q    <= 32'd0;
            left_q   <= 32'd0;
            csum_q   <= 32'd0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (len_zero) begin
                            done_q <= 1'b1;
                            csum_q <= 32'd0;
                        end else if (range_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            rom_a_q <= src_base_i;
                            dst_q   <= dst_base_i;
                            left_q  <= len_i;
                            csum_q  <= 32'd0;
                        end
                    end
                end
                FILL: begin
                    // RAM_A moves to the first sink address only as the first write begins
                    if (!abort_i) begin
                        rom_a_q  <= rom_a_q + 32'd1;
                        wr_ptr_q <= dst_q;
                    end
                end
                STREAM: begin
                    if (write_en) begin
                        rom_a_q  <= rom_a_q + 32'd1;
                        wr_ptr_q <= wr_ptr_q + 32'd1;
                        csum_q   <= csum_q + rom_q_i;
                        left_q   <= left_q - 32'd1;
                    end
                end
                DRAIN: begin
                    // wr_ptr stays on the last address so RAM_A holds afterwards
                    if (write_en) begin
                        csum_q <= csum_q + rom_q_i;
                        left_q <= left_q - 32'd1;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign rom_a_o  = rom_a_q;
    assign ram_a_o  = wr_ptr_q;
    assign ram_d_o  = rom_q_i;
    assign ram_we_o = write_en;
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign csum_o   = csum_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: ROM/RAM models around the DUT, directed and
// random copies checked against expectations derived from copy arithmetic.
`timescale 1ns/1ps
module tb_mem_copy_engine;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [31:0] src_base_i = '0;
    logic [31:0] dst_base_i = '0;
    logic [31:0] len_i = '0;
    logic [31:0] rom_a_o;
    logic [31:0] rom_q_i = '0;
    logic [31:0] ram_a_o;
    logic [31:0] ram_d_o;
    logic        ram_we_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] csum_o;

    mem_copy_engine #(.ROM_LEN(128), .RAM_LEN(1024)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .abort_i(abort_i),
        .src_base_i(src_base_i), .dst_base_i(dst_base_i), .len_i(len_i),
        .rom_a_o(rom_a_o), .rom_q_i(rom_q_i), .ram_a_o(ram_a_o), .ram_d_o(ram_d_o),
        .ram_we_o(ram_we_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .csum_o(csum_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          edge_n;
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic [31:0] rom [128];
    logic [31:0] ram_mem [1024];
    wr_t         wq[$];
    int          ecnt = 0;
    int          busy_cnt = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] exp_csum = '0;

    always @(posedge clk_i) ecnt++;

    always @(posedge clk_i) begin
        logic [31:0] ra;
        ra = rom_a_o;
        rom_q_i <= rom[ra[6:0]];
    end

    // A write seen in this cycle commits at the next edge
    always @(negedge clk_i) begin
        logic [31:0] wa;
        wa = ram_a_o;
        if (busy_o) busy_cnt++;
        if (ram_we_o) begin
            wq.push_back('{edge_n: ecnt + 1, a: ram_a_o, d: ram_d_o});
            ram_mem[wa[9:0]] = ram_d_o;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rom_at(input logic [31:0] addr);
        return rom[addr[6:0]];
    endfunction

    // Called at posedge+#1; returns at posedge+#1 (tail cycles after DONE/ERR/abort).
    task automatic do_copy(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                           input int abort_at, input bit poke, input int tail);
        int          e0, done_e, err_e, n, cyc, tail_left, budget;
        bit          ended, aborted, timed_out, bad;
        logic [31:0] sum, idx;
        wq.delete();
        busy_cnt   = 0;
        src_base_i = s;
        dst_base_i = d;
        len_i      = l;
        start_i    = 1'b1;
        e0 = ecnt + 1;
        done_e = -1; err_e = -1;
        ended = 0; aborted = 0; timed_out = 0;
        tail_left = tail;
        budget = (l > 32'd20) ? 20 : int'(l) + 12;
        cyc = 0;
        while (1) begin
            @(posedge clk_i); #1;
            cyc++;
            start_i = 1'b0;
            abort_i = 1'b0;
            if (done_o) done_e = ecnt;
            if (err_o)  err_e  = ecnt;
            if (poke && cyc == 2) begin
                start_i = 1'b1; src_base_i = 32'd7; dst_base_i = 32'd3; len_i = 32'd1;
            end
            if (!ended && (done_e >= 0 || err_e >= 0 || (aborted && !busy_o))) ended = 1;
            if (abort_at >= 0 && !aborted && wq.size() == abort_at && busy_o) begin
                abort_i = 1'b1;
                aborted = 1;
            end
            if (ended) begin
                if (tail_left == 0) break;
                tail_left--;
            end
            if (cyc > budget) begin
                timed_out = 1;
                break;
            end
        end
        abort_i = 1'b0;
        start_i = 1'b0;
        n = wq.size();
        if (timed_out) chk("timeout", 32'd1, 32'd0);
        bad = (longint'(s) + longint'(l) > 128) || (longint'(d) + longint'(l) > 1024);
        if (l == 0) begin
            chk("len0_done_edge", done_e, e0);
            chk("len0_writes", n, 0);
            chk("len0_busy", busy_cnt, 0);
            exp_csum = '0;
        end else if (bad) begin
            chk("range_err_edge", err_e, e0);
            chk("range_writes", n, 0);
            chk("range_busy", busy_cnt, 0);
            chk("range_no_done", done_e, -1);
        end else if (abort_at >= 0) begin
            chk("abort_count", (n == abort_at || n == abort_at + 1), 1'b1);
            chk("abort_no_done", done_e, -1);
            sum = '0;
            for (int k = 0; k < n; k++) begin
                chk("abort_addr", wq[k].a, d + k);
                chk("abort_data", wq[k].d, rom_at(s + k));
                sum += rom_at(s + k);
            end
            exp_csum = sum;
        end else begin
            chk("writes", n, l);
            sum = '0;
            for (int k = 0; k < n && k < int'(l); k++) begin
                idx = d + k;
                chk("wr_edge", wq[k].edge_n, e0 + k + 2);
                chk("wr_addr", wq[k].a, d + k);
                chk("wr_data", wq[k].d, rom_at(s + k));
                chk("ram_content", ram_mem[idx[9:0]], rom_at(s + k));
            end
            for (int k = 0; k < int'(l); k++) sum += rom_at(s + k);
            chk("done_edge", done_e, e0 + int'(l) + 1);
            chk("busy_cycles", busy_cnt, l + 1);
            exp_csum = sum;
        end
        chk("csum", csum_o, exp_csum);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"}, busy_o, 1'b0);
        chk({tag, "_we"}, ram_we_o, 1'b0);
        chk({tag, "_done"}, done_o, 1'b0);
        chk({tag, "_err"}, err_o, 1'b0);
        chk({tag, "_csum"}, csum_o, 32'd0);
        chk({tag, "_rom_a"}, rom_a_o, 32'd0);
        chk({tag, "_ram_a"}, ram_a_o, 32'd0);
    endtask

    initial begin
        int          dones;
        int          l, s, d, ab;
        for (int i = 0; i < 128; i++) rom[i] = $urandom;
        for (int i = 0; i < 1024; i++) ram_mem[i] = '0;
        rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;

        rst_n_i = 1'b0;
        start_i = 1'b1;
        abort_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk_reset_state("reset");
        start_i = 1'b0;
        abort_i = 1'b0;
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        do_copy(32'd0, 32'h100, 32'd4, -1, 0, 2);
        chk("nominal_csum_aa", csum_o, 32'hAA);
        do_copy(32'd10, 32'd20, 32'd1, -1, 0, 2);
        do_copy(32'd5, 32'd30, 32'd0, -1, 0, 2);
        do_copy(32'd0, 32'd1020, 32'd8, -1, 0, 2);
        do_copy(32'hFFFF_FFFF, 32'd0, 32'd2, -1, 0, 2);
        do_copy(32'd20, 32'd200, 32'd6, 2, 0, 2);
        do_copy(32'd40, 32'd300, 32'd6, -1, 1, 2);

        // Reset in the middle of a copy
        src_base_i = 32'd64; dst_base_i = 32'd600; len_i = 32'd6; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_n_i = 1'b0;
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        chk_reset_state("midreset");
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i); #1;
            if (done_o) dones++;
        end
        chk("midreset_no_done", dones, 0);
        exp_csum = '0;
        do_copy(32'd70, 32'd610, 32'd5, -1, 0, 2);

        // Back-to-back: second START in the DONE cycle of the first
        do_copy(32'd50, 32'd400, 32'd3, -1, 0, 0);
        do_copy(32'd60, 32'd500, 32'd5, -1, 0, 2);

        for (int it = 0; it < 12; it++) begin
            l = $urandom_range(0, 12);
            s = $urandom_range(0, 128 - l);
            d = $urandom_range(0, 1024 - l);
            if ($urandom_range(0, 4) == 0) d = 1024 - l + 1 + $urandom_range(0, 5);
            ab = -1;
            if (l >= 1 && $urandom_range(0, 4) == 0) ab = $urandom_range(0, l - 1);
            do_copy(s, d, l, ab, 0, 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
